// File: rtl/seq_detect_ctrl_if.sv
// Handshake and data bundle between a controlling master and the seq_detect_ctrl serial pattern detector.
interface seq_detect_ctrl_if #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [3:0]        cfg_len;
    logic              cfg_overlap;
    logic              cfg_err;
    logic [7:0]        win_len;
    logic              start;
    logic              abort;
    logic              x_valid;
    logic              x;
    logic              busy;
    logic              match;
    logic              done;
    logic [CNT_W-1:0]  match_cnt;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, win_len,
               start, abort, x_valid, x,
        input  cfg_ready, cfg_err, busy, match, done, match_cnt
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, win_len,
               start, abort, x_valid, x,
        output cfg_ready, cfg_err, busy, match, done, match_cnt
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector: counts (overlapping or non-overlapping) pattern hits over
// a bounded or unbounded window of qualified input bits.
module seq_detect_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    seq_detect_ctrl_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(MAXLEN + 1);
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned WIN_W  = 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [MAXLEN-1:0] r_pattern;
    logic [LEN_W-1:0]  r_len;
    logic              r_overlap;
    logic [MAXLEN-1:0] r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [WIN_W-1:0]  r_bit_cnt;
    logic [WIN_W-1:0]  r_win_len;
    logic [CNT_W-1:0]  r_match_cnt;
    logic              r_match;
    logic              r_cfg_err;

    logic              w_cfg_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_sample;
    logic              w_cfg_req;
    logic              w_cfg_ok;
    logic              w_hit;
    logic              w_last;
    logic [MAXLEN-1:0] w_hist_next;
    logic [MAXLEN-1:0] w_mask;
    logic [FILL_W-1:0] w_fill_inc;
    logic [WIN_W-1:0]  w_bit_next;

    // An abort in RUN suppresses the sample of the same cycle entirely.
    assign w_sample    = (r_state == S_RUN) && bus.x_valid && !bus.abort;
    assign w_cfg_req   = (r_state == S_IDLE) && bus.cfg_valid;
    assign w_cfg_ok    = (bus.cfg_len != '0) && (32'(bus.cfg_len) <= MAXLEN);
    assign w_hist_next = {r_hist[MAXLEN-2:0], bus.x};
    assign w_fill_inc  = (32'(r_fill) >= MAXLEN) ? r_fill : r_fill + FILL_W'(1);
    assign w_bit_next  = r_bit_cnt + WIN_W'(1);
    assign w_last      = (r_win_len != '0) && (w_bit_next == r_win_len);

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(MAXLEN); i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    assign w_hit = (32'(w_fill_inc) >= 32'(r_len)) &&
                   ((w_hist_next & w_mask) == (r_pattern & w_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // A configuration request takes priority over start in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start && !bus.cfg_valid) w_state_next = S_RUN;
            S_RUN: begin
                if (bus.abort)                w_state_next = S_IDLE;
                else if (w_sample && w_last)  w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cfg_ready = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:  w_cfg_ready = 1'b1;
            S_RUN:   w_busy      = 1'b1;
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: w_cfg_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern   <= MAXLEN'(4'b1011);
            r_len       <= LEN_W'(4);
            r_overlap   <= 1'b1;
            r_hist      <= '0;
            r_fill      <= '0;
            r_bit_cnt   <= '0;
            r_win_len   <= '0;
            r_match_cnt <= '0;
            r_match     <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
            if (w_cfg_req) begin
                if (w_cfg_ok) begin
                    r_pattern <= bus.cfg_pattern;
                    r_len     <= bus.cfg_len;
                    r_overlap <= bus.cfg_overlap;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if ((r_state == S_IDLE) && bus.start) begin
                r_win_len   <= bus.win_len;
                r_match_cnt <= '0;
                r_bit_cnt   <= '0;
                r_fill      <= '0;
                r_hist      <= '0;
            end
            if (w_sample) begin
                r_hist    <= w_hist_next;
                r_bit_cnt <= w_bit_next;
                r_match   <= w_hit;
                if (w_hit) begin
                    if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + CNT_W'(1);
                    r_fill <= r_overlap ? w_fill_inc : '0;
                end else begin
                    r_fill <= w_fill_inc;
                end
            end
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.match     = r_match;
    assign bus.cfg_err   = r_cfg_err;
    assign bus.match_cnt = r_match_cnt;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_detect_ctrl_if #(.MAXLEN(8), .CNT_W(8)) sd_if ();

    seq_detect_ctrl #(.MAXLEN(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sd_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        sd_if.cfg_valid   = 1'b1;
        sd_if.cfg_pattern = pat;
        sd_if.cfg_len     = len;
        sd_if.cfg_overlap = ov;
        tick();
        sd_if.cfg_valid   = 1'b0;
        check("cfg_err_legal", 32'(sd_if.cfg_err), 32'd0);
    endtask

    task automatic begin_run(input logic [7:0] win);
        sd_if.win_len = win;
        sd_if.start   = 1'b1;
        tick();
        sd_if.start   = 1'b0;
        check("run_busy", 32'(sd_if.busy), 32'd1);
        check("run_cfg_ready", 32'(sd_if.cfg_ready), 32'd0);
    endtask

    // Bits sent MSB first; exp_m bit (n-1-i) is the match expected after the i-th bit.
    task automatic run_stream(input string tag, input logic [31:0] bits, input int n,
                              input logic [31:0] exp_m);
        for (int i = 0; i < n; i++) begin
            sd_if.x_valid = 1'b1;
            sd_if.x       = bits[n-1-i];
            tick();
            check(tag, 32'(sd_if.match), 32'(exp_m[n-1-i]));
        end
        sd_if.x_valid = 1'b0;
    endtask

    task automatic check_idle_after_done(input string tag, input logic [7:0] cnt);
        check({tag, "_done"}, 32'(sd_if.done), 32'd1);
        check({tag, "_cnt"}, 32'(sd_if.match_cnt), 32'(cnt));
        tick();
        check({tag, "_done_clr"}, 32'(sd_if.done), 32'd0);
        check({tag, "_idle"}, 32'(sd_if.cfg_ready), 32'd1);
        check({tag, "_cnt_hold"}, 32'(sd_if.match_cnt), 32'(cnt));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, 32'(sd_if.cfg_ready), 32'd1);
        check({tag, "_busy"}, 32'(sd_if.busy), 32'd0);
        check({tag, "_match"}, 32'(sd_if.match), 32'd0);
        check({tag, "_done"}, 32'(sd_if.done), 32'd0);
        check({tag, "_cfg_err"}, 32'(sd_if.cfg_err), 32'd0);
        check({tag, "_cnt"}, 32'(sd_if.match_cnt), 32'd0);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        sd_if.cfg_valid   = 1'b0;
        sd_if.cfg_pattern = '0;
        sd_if.cfg_len     = '0;
        sd_if.cfg_overlap = 1'b0;
        sd_if.win_len     = '0;
        sd_if.start       = 1'b0;
        sd_if.abort       = 1'b0;
        sd_if.x_valid     = 1'b0;
        sd_if.x           = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Default pattern 1011, overlapping, window of 7 bits.
        begin_run(8'd7);
        run_stream("def_match", 32'b1011011, 7, 32'b0001001);
        check_idle_after_done("def", 8'd2);

        // Pattern 111 non-overlapping, then overlapping.
        load_cfg(8'b111, 4'd3, 1'b0);
        begin_run(8'd5);
        run_stream("novl_match", 32'b11111, 5, 32'b00100);
        check_idle_after_done("novl", 8'd1);
        load_cfg(8'b111, 4'd3, 1'b1);
        begin_run(8'd5);
        run_stream("ovl_match", 32'b11111, 5, 32'b00111);
        check_idle_after_done("ovl", 8'd3);

        // Illegal length rejected; config and start together: start ignored.
        load_cfg(8'b1011, 4'd4, 1'b1);
        sd_if.cfg_valid   = 1'b1;
        sd_if.cfg_pattern = 8'b111;
        sd_if.cfg_len     = 4'd9;
        sd_if.start       = 1'b1;
        tick();
        sd_if.cfg_valid   = 1'b0;
        sd_if.start       = 1'b0;
        check("len9_err", 32'(sd_if.cfg_err), 32'd1);
        check("cfg_start_no_run", 32'(sd_if.busy), 32'd0);
        tick();
        check("len9_err_pulse", 32'(sd_if.cfg_err), 32'd0);
        sd_if.cfg_valid   = 1'b1;
        sd_if.cfg_len     = 4'd0;
        tick();
        sd_if.cfg_valid   = 1'b0;
        check("len0_err", 32'(sd_if.cfg_err), 32'd1);
        begin_run(8'd4);
        sd_if.cfg_valid   = 1'b1;
        sd_if.cfg_pattern = 8'b111;
        sd_if.cfg_len     = 4'd3;
        tick();
        check("run_cfg_ready0", 32'(sd_if.cfg_ready), 32'd0);
        check("run_cfg_no_err", 32'(sd_if.cfg_err), 32'd0);
        sd_if.cfg_valid   = 1'b0;
        run_stream("old_cfg_match", 32'b1011, 4, 32'b0001);
        check_idle_after_done("old_cfg", 8'd1);

        // Abort on the final sample wins over match and done.
        load_cfg(8'b1, 4'd1, 1'b1);
        begin_run(8'd2);
        run_stream("abort_pre", 32'b1, 1, 32'b1);
        sd_if.x_valid = 1'b1;
        sd_if.x       = 1'b1;
        sd_if.abort   = 1'b1;
        tick();
        sd_if.x_valid = 1'b0;
        sd_if.abort   = 1'b0;
        check("abort_last_match", 32'(sd_if.match), 32'd0);
        check("abort_last_done", 32'(sd_if.done), 32'd0);
        check("abort_last_idle", 32'(sd_if.busy), 32'd0);
        check("abort_last_cnt", 32'(sd_if.match_cnt), 32'd1);

        // Unbounded window: counter saturates, abort keeps the count.
        begin_run(8'd0);
        sd_if.x_valid = 1'b1;
        sd_if.x       = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        sd_if.x_valid = 1'b0;
        check("sat_cnt", 32'(sd_if.match_cnt), 32'd255);
        check("sat_match", 32'(sd_if.match), 32'd1);
        check("sat_busy", 32'(sd_if.busy), 32'd1);
        sd_if.abort = 1'b1;
        tick();
        sd_if.abort = 1'b0;
        check("sat_abort_idle", 32'(sd_if.busy), 32'd0);
        check("sat_abort_done", 32'(sd_if.done), 32'd0);
        check("sat_abort_cnt", 32'(sd_if.match_cnt), 32'd255);
        tick();
        check("sat_abort_done2", 32'(sd_if.done), 32'd0);
        sd_if.abort = 1'b1;
        tick();
        sd_if.abort = 1'b0;
        check("idle_abort_noeff", 32'(sd_if.cfg_ready), 32'd1);

        // Gapped x_valid: one sample every third cycle.
        load_cfg(8'b1011, 4'd4, 1'b1);
        begin_run(8'd0);
        begin
            logic [3:0] gbits;
            gbits = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                sd_if.x_valid = 1'b1;
                sd_if.x       = gbits[3-i];
                tick();
                sd_if.x_valid = 1'b0;
                check("gap_match", 32'(sd_if.match), (i == 3) ? 32'd1 : 32'd0);
                tick();
                check("gap_hold0", 32'(sd_if.match), 32'd0);
                tick();
                check("gap_hold1", 32'(sd_if.match), 32'd0);
            end
        end
        check("gap_cnt", 32'(sd_if.match_cnt), 32'd1);

        // Reset mid-run abandons the run.
        sd_if.x_valid = 1'b1;
        sd_if.x       = 1'b1;
        rst           = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        sd_if.x_valid = 1'b0;
        rst           = 1'b0;
        tick();
        check("post_rst_done", 32'(sd_if.done), 32'd0);
        check("post_rst_match", 32'(sd_if.match), 32'd0);
        check("post_rst_busy", 32'(sd_if.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
